// File: rtl/glyph_pixel_pipe.sv
// Glyph-to-pixel serializer: raster position -> character ROM row address -> pixel bit.
// Fixed three-stage pipeline with frame-latched origin/char/mirror and power-of-two scaling.
module glyph_pixel_pipe #(
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned GLYPH_W    = 16,
  parameter int unsigned GLYPH_H    = 16,
  parameter int unsigned CHAR_W     = 7,
  parameter int unsigned SCALE_LOG2 = 0,
  localparam int unsigned ROW_W     = $clog2(GLYPH_H)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    frame_start,
  input  logic [COORD_W-1:0]      x_pos,
  input  logic [COORD_W-1:0]      y_pos,
  input  logic [CHAR_W-1:0]       char_code,
  input  logic                    mirror_x,
  input  logic [COORD_W-1:0]      h_val,
  input  logic [COORD_W-1:0]      v_val,
  output logic [CHAR_W+ROW_W-1:0] rom_addr,
  input  logic [GLYPH_W-1:0]      rom_data,
  output logic                    in_box,
  output logic                    pixel_on
);

  localparam int unsigned COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned BOX_W = GLYPH_W << SCALE_LOG2;
  localparam int unsigned BOX_H = GLYPH_H << SCALE_LOG2;

  logic [COORD_W-1:0] r_x_sh;
  logic [COORD_W-1:0] r_y_sh;
  logic [CHAR_W-1:0]  r_ch_sh;
  logic               r_mir_sh;

  logic [COL_W-1:0]   r_col_q;
  logic [COL_W-1:0]   r_col_qq;
  logic               r_hit_q;
  logic               r_hit_qq;
  logic               r_mir_q;
  logic               r_mir_qq;

  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;
  logic               w_hit;
  logic [COL_W-1:0]   w_col;
  logic [ROW_W-1:0]   w_row;
  logic [COL_W-1:0]   w_idx;
  logic               w_bit;

  // Box test: modular offset plus an explicit ordering check so a box past the raster edge clips.
  always_comb begin
    w_dx  = h_val - r_x_sh;
    w_dy  = v_val - r_y_sh;
    w_hit = enable
            && (h_val >= r_x_sh) && (v_val >= r_y_sh)
            && (32'(w_dx) < BOX_W) && (32'(w_dy) < BOX_H);
    w_col = COL_W'(w_dx >> SCALE_LOG2);
    w_row = w_hit ? ROW_W'(w_dy >> SCALE_LOG2) : '0;
  end

  // Column 0 sits on the ROM MSB unless mirrored.
  always_comb begin
    w_idx = r_mir_qq ? r_col_qq : (COL_W'(GLYPH_W - 1) - r_col_qq);
    w_bit = rom_data[w_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x_sh   <= '0;
      r_y_sh   <= '0;
      r_ch_sh  <= '0;
      r_mir_sh <= 1'b0;
      rom_addr <= '0;
      r_col_q  <= '0;
      r_hit_q  <= 1'b0;
      r_mir_q  <= 1'b0;
      r_col_qq <= '0;
      r_hit_qq <= 1'b0;
      r_mir_qq <= 1'b0;
      in_box   <= 1'b0;
      pixel_on <= 1'b0;
    end else begin
      if (frame_start) begin
        r_x_sh   <= x_pos;
        r_y_sh   <= y_pos;
        r_ch_sh  <= char_code;
        r_mir_sh <= mirror_x;
      end
      rom_addr <= {r_ch_sh, w_row};
      r_col_q  <= w_col;
      r_hit_q  <= w_hit;
      r_mir_q  <= r_mir_sh;
      // Second stage lines the column up with the registered ROM read.
      r_col_qq <= r_col_q;
      r_hit_qq <= r_hit_q;
      r_mir_qq <= r_mir_q;
      in_box   <= r_hit_qq;
      pixel_on <= r_hit_qq & w_bit;
    end
  end

endmodule
